// File: rtl/dct_sequencer_if.sv
// Control bus of the 2-D 8x8 DCT sequencer: the start request and the pipelined
// buffer/ROM/accumulator strobes. The master modport belongs to the sequencer.
// The optional abort input exists only when DCT_SEQ_ABORT_EN is defined.
interface dct_sequencer_if;
  logic       start;
`ifdef DCT_SEQ_ABORT_EN
  logic       abort;
`endif
  logic       busy;
  logic       done;
  logic [5:0] rd_addr;
  logic       rd_sel;
  logic [2:0] rom_addr;
  logic       acc_load;
  logic       acc_en;
  logic       wr_en;
  logic [2:0] wr_row;
  logic       wr_sel;

  modport master (
    input  start,
`ifdef DCT_SEQ_ABORT_EN
    input  abort,
`endif
    output busy, done, rd_addr, rd_sel, rom_addr, acc_load, acc_en, wr_en, wr_row, wr_sel
  );

  modport slave (
    output start,
`ifdef DCT_SEQ_ABORT_EN
    output abort,
`endif
    input  busy, done, rd_addr, rd_sel, rom_addr, acc_load, acc_en, wr_en, wr_row, wr_sel
  );
endinterface

// File: rtl/dct_sequencer.sv
// Sequencer for a row/column 2-D 8x8 DCT: pass 1 reads the input buffer row-wise
// into the transpose buffer, pass 2 reads the transpose buffer column-wise into
// the output buffer. Three-stage timing: issue (read address), stage 1
// (accumulate with ROM row), stage 2 (write all accumulators after j==7).
// Every output is a flop; next values are derived from the next state.
// Optional feature: define DCT_SEQ_ABORT_EN to add the abort input.
module dct_sequencer #(
  parameter int unsigned ROWS = 8
) (
  input logic            clock,
  input logic            rst_n,
  dct_sequencer_if.master bus
);

  localparam logic [2:0] Last = 3'(ROWS - 1);

  typedef enum logic [2:0] {StIdle, StPass1, StFlush1, StPass2, StFlush2, StDone} state_e;

  state_e     state_q, state_d;
  logic [2:0] r_q, r_d, j_q, j_d;
  logic       flush_q, flush_d;
  // Issue-stage outputs
  logic [5:0] rd_addr_q, rd_addr_d;
  logic       rd_sel_q, rd_sel_d;
  // Stage 1
  logic       acc_en_q, acc_en_d, acc_load_q, acc_load_d;
  logic [2:0] rom_addr_q, rom_addr_d, s1_row_q, s1_row_d;
  logic       s1_pass2_q, s1_pass2_d;
  // Stage 2
  logic       wr_en_q, wr_en_d, wr_sel_q, wr_sel_d;
  logic [2:0] wr_row_q, wr_row_d;
  logic       busy_q, busy_d, done_q, done_d;
  logic       issue;
  logic       kill;

  // Next-state, counters and the registered pipeline/output values
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    j_d     = j_q;
    flush_d = flush_q;
    issue   = (state_q == StPass1) || (state_q == StPass2);
    kill    = 1'b0;

    unique case (state_q)
      StIdle: if (bus.start) state_d = StPass1;
      StPass1, StPass2: begin
        j_d = j_q + 3'd1;
        if (j_q == Last) begin
          r_d = r_q + 3'd1;
          if (r_q == Last) state_d = (state_q == StPass1) ? StFlush1 : StFlush2;
        end
      end
      // Two idle issue slots let stages 1-2 drain before the next phase
      StFlush1, StFlush2: begin
        flush_d = ~flush_q;
        if (flush_q) state_d = (state_q == StFlush1) ? StPass2 : StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

`ifdef DCT_SEQ_ABORT_EN
    kill = bus.abort && (state_q != StIdle);
    if (kill) begin
      state_d = StIdle;
      r_d     = 3'd0;
      j_d     = 3'd0;
      flush_d = 1'b0;
    end
`endif

    // Issue stage follows the state being entered so it appears with it
    rd_sel_d  = (state_d == StPass2);
    rd_addr_d = 6'd0;
    if (state_d == StPass1)      rd_addr_d = {r_d, j_d};
    else if (state_d == StPass2) rd_addr_d = {j_d, r_d};

    // Stage 1 captures the address issued during the current cycle
    acc_en_d   = issue && !kill;
    acc_load_d = acc_en_d && (j_q == 3'd0);
    rom_addr_d = acc_en_d ? j_q : 3'd0;
    s1_row_d   = acc_en_d ? r_q : 3'd0;
    s1_pass2_d = acc_en_d && (state_q == StPass2);

    // Stage 2 writes once the last coefficient of a row/column has accumulated
    wr_en_d  = acc_en_q && (rom_addr_q == Last) && !kill;
    wr_row_d = wr_en_d ? s1_row_q : 3'd0;
    wr_sel_d = wr_en_d && s1_pass2_q;

    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  // State, counters and output registers with asynchronous clear
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      r_q        <= 3'd0;
      j_q        <= 3'd0;
      flush_q    <= 1'b0;
      rd_addr_q  <= 6'd0;
      rd_sel_q   <= 1'b0;
      acc_en_q   <= 1'b0;
      acc_load_q <= 1'b0;
      rom_addr_q <= 3'd0;
      s1_row_q   <= 3'd0;
      s1_pass2_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_row_q   <= 3'd0;
      wr_sel_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      j_q        <= j_d;
      flush_q    <= flush_d;
      rd_addr_q  <= rd_addr_d;
      rd_sel_q   <= rd_sel_d;
      acc_en_q   <= acc_en_d;
      acc_load_q <= acc_load_d;
      rom_addr_q <= rom_addr_d;
      s1_row_q   <= s1_row_d;
      s1_pass2_q <= s1_pass2_d;
      wr_en_q    <= wr_en_d;
      wr_row_q   <= wr_row_d;
      wr_sel_q   <= wr_sel_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.rd_sel   = rd_sel_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.acc_load = acc_load_q;
  assign bus.acc_en   = acc_en_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_row   = wr_row_q;
  assign bus.wr_sel   = wr_sel_q;

endmodule

// File: doc/dct_sequencer.md
DCT_SEQUENCER -- requirements
Module: dct_sequencer

Interface
REQ-001 Parameter ROWS, default 8, SHALL set the block dimension; only 8 is supported, matching the 3-bit coefficient ROM row address.
REQ-002 clock  in  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  request one 2-D 8x8 transform; sampled only in IDLE.
REQ-005 busy  out  1  high in every state except IDLE.
REQ-006 done  out  1  one-cycle completion pulse.
REQ-007 rd_addr  out  6  sample-buffer read address; buffer data is valid one cycle later.
REQ-008 rd_sel  out  1  0 = input buffer (pass 1), 1 = transpose buffer (pass 2).
REQ-009 rom_addr  out  3  coefficient ROM row address, aligned with the returned sample.
REQ-010 acc_load  out  1  accumulators load the product instead of adding it.
REQ-011 acc_en  out  1  accumulators update this cycle.
REQ-012 wr_en  out  1  write all 8 accumulator results.
REQ-013 wr_row  out  3  destination row or column for the wr_en write.
REQ-014 wr_sel  out  1  0 = transpose buffer, 1 = output buffer.

Function
REQ-015 States SHALL be IDLE, PASS1, FLUSH1, PASS2, FLUSH2 and DONE.
REQ-016 IDLE->PASS1 on start=1; PASS1->FLUSH1 after 64 cycles; FLUSH1->PASS2 after 2 cycles; PASS2->FLUSH2 after 64 cycles; FLUSH2->DONE after 2 cycles; DONE->IDLE after 1 cycle.
REQ-017 In PASS1/PASS2, 3-bit counters r (outer) and j (inner) SHALL step j 0..7, then wrap j to 0 and increment r, covering 64 issue cycles.
REQ-018 Issue stage: PASS1 rd_addr={r,j} with rd_sel=0; PASS2 rd_addr={j,r} with rd_sel=1; rd_addr SHALL be 0 outside the PASS states.
REQ-019 Stage 1, registered one cycle after issue: acc_en=1, rom_addr=j, acc_load=(j==0).
REQ-020 Stage 2, registered one cycle after stage 1: wr_en=1 only when the stage-1 j was 7; wr_row=r; wr_sel=0 for pass 1 and 1 for pass 2.
REQ-021 The FLUSH states SHALL drain stages 1-2 with no new issue, so the transpose buffer is complete before pass 2 reads it.
REQ-022 With start sampled at edge E0: pass-1 writes occur at E9+8k (k=0..7); done SHALL be high between E132 and E133; busy SHALL be low from E133.
REQ-023 start while busy SHALL be ignored; start held high SHALL restart at the first IDLE cycle after DONE.
REQ-024 Outputs SHALL be registered, with no combinational path from start to any output.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, r=j=0, clear the pipeline, and drive every output to 0, including mid-pass; no write SHALL follow a reset.

Configuration
REQ-026 Macro DCT_SEQ_ABORT_EN defined: adds input abort (1 bit) after start; abort=1 in any busy state SHALL return to IDLE at the next edge, clear the pipeline, and suppress wr_en and done. Undefined: no abort port, and a transform always runs to DONE.

Verification
REQ-027 Reset, then start=1 for one cycle at E0 -> first rd_addr=0x00 with rd_sel=0; at E1 acc_load=1, acc_en=1, rom_addr=0; first wr_en with wr_row=0, wr_sel=0 at E9.
REQ-028 Full run -> pass-2 issue sequence rd_addr=0x00,0x08,...,0x38,0x01,...; 16 wr_en pulses total; done is one cycle between E132 and E133.
REQ-029 start pulsed at E5 and E100 during a run -> ignored; exactly one done; no output difference from a single run.
REQ-030 rst_n low during PASS2 (cycle 80) -> all outputs 0 asynchronously; after release with no start, the block stays IDLE.
REQ-031 start held high for 300 cycles -> two back-to-back transforms; second issue begins one cycle after the first DONE.
REQ-032 With DCT_SEQ_ABORT_EN defined, abort at cycle 40 -> IDLE next edge; no further wr_en; no done.
